iter_shifter: RTL and testbench

Parametrised iterative shift/rotate unit for the Mini SRC datapath ALU. It implements SHL, SHR, SHRA, ROL and ROR on a WIDTH-bit operand, moving up to STEP bit positions per clock. A start/busy/done handshake lets the control unit hold the datapath, for example stretching T4, until `done` arrives and Zlow can be loaded from `result`. The unit replaces the single-cycle shifter wherever area matters more than latency.

---
 rtl/iter_shifter_if.sv | 49 ++++
 rtl/iter_shifter.sv | 167 ++++++++++++++++
 tb/tb_iter_shifter.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iter_shifter_if.sv
// ----------------------------------------------------------------------------
// iter_shifter_if
//
// Groups the request and response signals of the iterative shift/rotate unit.
//
// Handshake:
//   The requester raises start with op/data_in/shamt valid. The unit takes
//   the request on a rising clock edge only when busy=0 and abort=0.
//   busy=1 means a request is in progress, and start is ignored. done is a
//   one-cycle pulse that marks result/shift_out as valid. Those values then
//   hold until the next request is taken. A start that arrives in the done
//   cycle is taken, so operations can run back to back.
//
// Signals:
//   start     requester -> unit   request strobe
//   abort     requester -> unit   cancel an operation in progress
//   op        requester -> unit   3-bit operation code
//   data_in   requester -> unit   WIDTH-bit operand
//   shamt     requester -> unit   shift count, $clog2(WIDTH) bits
//   result    unit -> requester   working/result register
//   shift_out unit -> requester   last bit shifted or rotated out
//   busy      unit -> requester   operation in progress
//   done      unit -> requester   one-cycle completion pulse
// ----------------------------------------------------------------------------
interface iter_shifter_if #(
    parameter int WIDTH = 32
);
    localparam int SW = $clog2(WIDTH);

    logic             start;
    logic             abort;
    logic [2:0]       op;
    logic [WIDTH-1:0] data_in;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] result;
    logic             shift_out;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, op, data_in, shamt,
        input  result, shift_out, busy, done
    );

    modport slave (
        input  start, abort, op, data_in, shamt,
        output result, shift_out, busy, done
    );
endinterface

// File: rtl/iter_shifter.sv
// ----------------------------------------------------------------------------
// iter_shifter
//
// Iterative shift/rotate unit for the Mini SRC ALU. It performs SHL, SHR,
// SHRA, ROL and ROR on a WIDTH-bit operand and moves at most STEP bit
// positions per clock. The control unit holds the datapath until done
// pulses, and then loads Zlow from result.
//
// Ports:
//   clock      rising-edge clock
//   clear      asynchronous active-low reset
//   bus        iter_shifter_if.slave (start/abort/op/data_in/shamt in;
//              result/shift_out/busy/done out)
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Parameters:
//   WIDTH  operand width: a power of two from 8 to 64
//   STEP   maximum shift per cycle: a power of two from 1 to WIDTH
// ----------------------------------------------------------------------------
module iter_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic              clock,
    input  logic              clear,
    iter_shifter_if.slave     bus,
    output logic [1:0]        state_dbg
);
    localparam int SW = $clog2(WIDTH);
    // Per-cycle step amount. One extra bit lets STEP == WIDTH be represented.
    localparam int KW = SW + 1;
    localparam logic [KW-1:0] STEP_K  = KW'(STEP);
    localparam logic [KW-1:0] WIDTH_K = KW'(WIDTH);

    localparam logic [2:0] OP_SHL  = 3'd0;
    localparam logic [2:0] OP_SHR  = 3'd1;
    localparam logic [2:0] OP_SHRA = 3'd2;
    localparam logic [2:0] OP_ROL  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q;
    logic             shift_out_q;
    logic [2:0]       op_q;
    logic [SW-1:0]    rem_q;

    logic             accept;
    logic             op_legal;
    logic [KW-1:0]    k;
    logic [SW-1:0]    rem_next;
    logic [WIDTH-1:0] step_res;
    logic             step_so;
    logic [WIDTH-1:0] tmp_hi;
    logic [WIDTH-1:0] tmp_lo;

    // A start is taken in IDLE or DONE, and abort blocks it.
    assign accept   = bus.start && !bus.abort && (state_q != S_RUN);
    assign op_legal = (bus.op <= OP_ROR);

    // In RUN the remaining count is never zero, so k >= 1 there.
    assign k        = ({1'b0, rem_q} >= STEP_K) ? STEP_K : {1'b0, rem_q};
    assign rem_next = rem_q - k[SW-1:0];

    // One step of k positions. The bit that leaves is the last one shifted
    // out of the word: index WIDTH-k for left shifts and k-1 for right shifts.
    // SHRA repeats the current MSB, which always equals the original MSB.
    always_comb begin
        step_res = result_q;
        step_so  = shift_out_q;
        tmp_hi   = result_q >> (WIDTH_K - k);
        tmp_lo   = result_q >> (k - KW'(1));
        case (op_q)
            OP_SHL: begin
                step_res = result_q << k;
                step_so  = tmp_hi[0];
            end
            OP_SHR: begin
                step_res = result_q >> k;
                step_so  = tmp_lo[0];
            end
            OP_SHRA: begin
                step_res = $unsigned($signed(result_q) >>> k);
                step_so  = tmp_lo[0];
            end
            OP_ROL: begin
                step_res = (result_q << k) | (result_q >> (WIDTH_K - k));
                step_so  = step_res[0];
            end
            OP_ROR: begin
                step_res = (result_q >> k) | (result_q << (WIDTH_K - k));
                step_so  = step_res[WIDTH-1];
            end
            default: begin
                step_res = result_q;
                step_so  = shift_out_q;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    // A zero count or an illegal op skips RUN, so done
                    // follows one cycle after the start is taken.
                    if ((bus.shamt == '0) || !op_legal) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (rem_next == '0) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath. An abort freezes result/shift_out at their partial values.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            result_q    <= '0;
            shift_out_q <= 1'b0;
            op_q        <= '0;
            rem_q       <= '0;
        end else if (accept) begin
            result_q    <= bus.data_in;
            shift_out_q <= 1'b0;
            op_q        <= bus.op;
            rem_q       <= bus.shamt;
        end else if ((state_q == S_RUN) && !bus.abort) begin
            result_q    <= step_res;
            shift_out_q <= step_so;
            rem_q       <= rem_next;
        end
    end

    // All outputs come straight from registers or state decode.
    assign bus.result    = result_q;
    assign bus.shift_out = shift_out_q;
    assign bus.busy      = (state_q == S_RUN);
    assign bus.done      = (state_q == S_DONE);
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_iter_shifter.sv
// ----------------------------------------------------------------------------
// tb_iter_shifter
//
// Bench for iter_shifter. Two instances share one clock and one reset: STEP=1
// (sel=0) and STEP=4 (sel=1), both with WIDTH=32. Each test task drives its
// own scenario and compares the outputs with values from a whole-shift
// reference model.
// ----------------------------------------------------------------------------
module tb_iter_shifter;
    localparam int W = 32;

    logic clock = 1'b0;
    logic clear;
    int   errors = 0;
    int   checks = 0;
    logic [W:0] exp_q[$];

    logic [1:0] st1, st4;

    iter_shifter_if #(.WIDTH(W)) if1 ();
    iter_shifter_if #(.WIDTH(W)) if4 ();

    iter_shifter #(.WIDTH(W), .STEP(1)) u_s1 (
        .clock(clock), .clear(clear), .bus(if1.slave), .state_dbg(st1)
    );
    iter_shifter #(.WIDTH(W), .STEP(4)) u_s4 (
        .clock(clock), .clear(clear), .bus(if4.slave), .state_dbg(st4)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    // Applies the whole shift at once, computed from the operation rules.
    function automatic void ref_op(input logic [2:0] op, input logic [W-1:0] d,
                                   input int n, output logic [W-1:0] res,
                                   output logic so);
        logic signed [W-1:0] sd;
        res = d;
        so  = 1'b0;
        if (n == 0 || op > 3'd4) return;
        case (op)
            3'd0: begin res = d << n; so = d[W-n]; end
            3'd1: begin res = d >> n; so = d[n-1]; end
            3'd2: begin sd = $signed(d) >>> n; res = sd; so = d[n-1]; end
            3'd3: begin res = (d << n) | (d >> (W-n)); so = res[0]; end
            default: begin res = (d >> n) | (d << (W-n)); so = res[W-1]; end
        endcase
    endfunction

    // Number of posedges from the drive edge until done is seen.
    function automatic int exp_lat(input bit sel, input logic [2:0] op, input int n);
        int stp;
        stp = sel ? 4 : 1;
        if (n == 0 || op > 3'd4) return 1;
        return (n + stp - 1) / stp + 1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input bit sel, input logic st, input logic ab,
                         input logic [2:0] op, input logic [W-1:0] d,
                         input logic [4:0] n);
        if (sel) begin
            if4.start = st; if4.abort = ab; if4.op = op; if4.data_in = d; if4.shamt = n;
        end else begin
            if1.start = st; if1.abort = ab; if1.op = op; if1.data_in = d; if1.shamt = n;
        end
    endtask

    task automatic sample(input bit sel, output logic [W-1:0] r, output logic so,
                          output logic b, output logic dn);
        if (sel) begin
            r = if4.result; so = if4.shift_out; b = if4.busy; dn = if4.done;
        end else begin
            r = if1.result; so = if1.shift_out; b = if1.busy; dn = if1.done;
        end
    endtask

    // Issues one operation and waits for done. Sampling happens 1 time unit
    // after each posedge. With no_sync=1 the start is driven at once, which
    // lands in the done cycle of the previous operation.
    task automatic run_op(input bit sel, input logic [2:0] op, input logic [W-1:0] d,
                          input logic [4:0] n, input bit no_sync,
                          output logic [W-1:0] res, output logic so,
                          output int lat, output int bcnt);
        logic b, dn;
        if (!no_sync) @(negedge clock);
        drive(sel, 1'b1, 1'b0, op, d, n);
        lat = 0; bcnt = 0; dn = 1'b0;
        while (!dn && lat < 60) begin
            @(posedge clock); #1;
            lat++;
            if (lat == 1) drive(sel, 1'b0, 1'b0, op, d, n);
            sample(sel, res, so, b, dn);
            if (b) bcnt++;
        end
        checks++;
        if (!dn) begin
            errors++;
            $display("FAIL run_op_timeout sel=%0d op=%0d n=%0d: done=0 after %0d cycles, required done=1",
                     sel, op, n, lat);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, '0, '0);
        #3;
        checks++;
        if ({if1.result, if1.shift_out, if1.busy, if1.done} !== '0) begin
            errors++;
            $display("FAIL reset_s1: result=%h so=%b busy=%b done=%b, required all 0",
                     if1.result, if1.shift_out, if1.busy, if1.done);
        end
        checks++;
        if ({if4.result, if4.shift_out, if4.busy, if4.done} !== '0) begin
            errors++;
            $display("FAIL reset_s4: result=%h so=%b busy=%b done=%b, required all 0",
                     if4.result, if4.shift_out, if4.busy, if4.done);
        end
        @(negedge clock); clear = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    typedef struct packed {
        logic        sel;
        logic [2:0]  op;
        logic [31:0] d;
        logic [4:0]  n;
        logic [31:0] res;
        logic        so;
        logic [7:0]  lat;
        logic [7:0]  bsy;
    } vec_t;

    task automatic test_directed();
        vec_t tbl [8];
        logic [W-1:0] r; logic so; int lat, bc;
        tbl[0] = '{1'b0, 3'd0, 32'h0F000000, 5'd4,  32'hF0000000, 1'b0, 8'd5, 8'd4};
        tbl[1] = '{1'b0, 3'd2, 32'h80000010, 5'd4,  32'hF8000001, 1'b0, 8'd5, 8'd4};
        tbl[2] = '{1'b0, 3'd4, 32'h0000000F, 5'd4,  32'hF0000000, 1'b1, 8'd5, 8'd4};
        tbl[3] = '{1'b0, 3'd1, 32'h00000001, 5'd1,  32'h00000000, 1'b1, 8'd2, 8'd1};
        tbl[4] = '{1'b0, 3'd0, 32'hA5A5A5A5, 5'd0,  32'hA5A5A5A5, 1'b0, 8'd1, 8'd0};
        tbl[5] = '{1'b0, 3'd6, 32'h12345678, 5'd7,  32'h12345678, 1'b0, 8'd1, 8'd0};
        tbl[6] = '{1'b1, 3'd0, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 8'd9, 8'd8};
        tbl[7] = '{1'b1, 3'd4, 32'h0000000F, 5'd4,  32'hF0000000, 1'b1, 8'd2, 8'd1};
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].sel, tbl[i].op, tbl[i].d, tbl[i].n, 1'b0, r, so, lat, bc);
            checks++;
            if ({r, so} !== {tbl[i].res, tbl[i].so}) begin
                errors++;
                $display("FAIL directed_%0d result: got %h so=%b, required %h so=%b",
                         i, r, so, tbl[i].res, tbl[i].so);
            end
            checks++;
            if (lat !== int'(tbl[i].lat) || bc !== int'(tbl[i].bsy)) begin
                errors++;
                $display("FAIL directed_%0d timing: done at +%0d busy=%0d cycles, required +%0d busy=%0d",
                         i, lat, bc, tbl[i].lat, tbl[i].bsy);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] r, er, d; logic so, eso; logic [W:0] e;
        logic [2:0] op; logic [4:0] n; bit sel; int lat, bc, el;
        for (int i = 0; i < 40; i++) begin
            sel = 1'($urandom_range(0, 1));
            op  = 3'($urandom_range(0, 7));
            d   = $urandom;
            n   = 5'($urandom_range(0, 31));
            ref_op(op, d, int'(n), er, eso);
            exp_q.push_back({eso, er});
            el = exp_lat(sel, op, int'(n));
            run_op(sel, op, d, n, 1'b0, r, so, lat, bc);
            e = exp_q.pop_front();
            checks++;
            if ({so, r} !== e) begin
                errors++;
                $display("FAIL random_%0d sel=%0d op=%0d d=%h n=%0d: got %h so=%b, required %h so=%b",
                         i, sel, op, d, n, r, so, e[W-1:0], e[W]);
            end
            checks++;
            if (lat !== el || bc !== (el - 1)) begin
                errors++;
                $display("FAIL random_%0d timing: done at +%0d busy=%0d, required +%0d busy=%0d",
                         i, lat, bc, el, el - 1);
            end
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] er, held; logic eso; int dn_cnt;
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 3'd3, 32'h12345678, 5'd8);
        @(posedge clock); #1;
        drive(1'b0, 1'b0, 1'b0, 3'd3, 32'h12345678, 5'd8);
        repeat (4) @(posedge clock);
        #1;
        ref_op(3'd3, 32'h12345678, 4, er, eso);
        checks++;
        if (if1.busy !== 1'b1 || if1.result !== er) begin
            errors++;
            $display("FAIL abort_partial: busy=%b result=%h, required busy=1 result=%h",
                     if1.busy, if1.result, er);
        end
        if1.abort = 1'b1;
        @(posedge clock); #1;
        if1.abort = 1'b0;
        checks++;
        if (if1.busy !== 1'b0 || if1.done !== 1'b0 || if1.result !== 32'h23456781 ||
            if1.shift_out !== eso) begin
            errors++;
            $display("FAIL abort_freeze: busy=%b done=%b result=%h so=%b, required 0 0 23456781 %b",
                     if1.busy, if1.done, if1.result, if1.shift_out, eso);
        end
        held = if1.result; dn_cnt = 0;
        repeat (10) begin
            @(posedge clock); #1;
            if (if1.done) dn_cnt++;
        end
        checks++;
        if (dn_cnt !== 0 || if1.result !== held) begin
            errors++;
            $display("FAIL abort_no_done: done pulses=%0d result=%h, required 0 pulses result=%h",
                     dn_cnt, if1.result, held);
        end
    endtask

    task automatic test_clear();
        int dn_cnt;
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 3'd3, 32'h12345678, 5'd8);
        @(posedge clock); #1;
        drive(1'b0, 1'b0, 1'b0, 3'd3, 32'h12345678, 5'd8);
        repeat (2) @(posedge clock);
        #2 clear = 1'b0;
        #1;
        checks++;
        if ({if1.result, if1.shift_out, if1.busy, if1.done} !== '0) begin
            errors++;
            $display("FAIL clear_async: result=%h so=%b busy=%b done=%b, required all 0",
                     if1.result, if1.shift_out, if1.busy, if1.done);
        end
        @(negedge clock); clear = 1'b1;
        dn_cnt = 0;
        repeat (12) begin
            @(posedge clock); #1;
            if (if1.done || if1.busy) dn_cnt++;
        end
        checks++;
        if (dn_cnt !== 0) begin
            errors++;
            $display("FAIL clear_no_done: busy/done cycles after clear=%0d, required 0", dn_cnt);
        end
    endtask

    task automatic test_start_ignored();
        logic [W-1:0] er; logic eso; int lat; logic dn;
        ref_op(3'd3, 32'h12345678, 8, er, eso);
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 3'd3, 32'h12345678, 5'd8);
        lat = 0; dn = 1'b0;
        while (!dn && lat < 60) begin
            @(posedge clock); #1;
            lat++;
            if (lat == 1) drive(1'b0, 1'b0, 1'b0, 3'd3, 32'h12345678, 5'd8);
            if (lat == 3) drive(1'b0, 1'b1, 1'b0, 3'd0, 32'hFFFF0000, 5'd3);
            if (lat == 4) drive(1'b0, 1'b0, 1'b0, 3'd0, 32'hFFFF0000, 5'd3);
            dn = if1.done;
        end
        checks++;
        if (lat !== 9 || if1.result !== er || if1.shift_out !== eso) begin
            errors++;
            $display("FAIL start_ignored: done at +%0d result=%h so=%b, required +9 %h %b",
                     lat, if1.result, if1.shift_out, er, eso);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r, er; logic so, eso; int lat, bc;
        run_op(1'b0, 3'd1, 32'hDEADBEEF, 5'd3, 1'b0, r, so, lat, bc);
        ref_op(3'd1, 32'hDEADBEEF, 3, er, eso);
        checks++;
        if (r !== er || so !== eso) begin
            errors++;
            $display("FAIL b2b_first: got %h so=%b, required %h so=%b", r, so, er, eso);
        end
        run_op(1'b0, 3'd3, 32'hCAFEF00D, 5'd5, 1'b1, r, so, lat, bc);
        ref_op(3'd3, 32'hCAFEF00D, 5, er, eso);
        checks++;
        if (r !== er || so !== eso || lat !== 6 || bc !== 5) begin
            errors++;
            $display("FAIL b2b_second: got %h so=%b at +%0d busy=%0d, required %h so=%b at +6 busy=5",
                     r, so, lat, bc, er, eso);
        end
        run_op(1'b1, 3'd2, 32'h80000000, 5'd0, 1'b0, r, so, lat, bc);
        run_op(1'b1, 3'd2, 32'h80000000, 5'd9, 1'b1, r, so, lat, bc);
        checks++;
        if (r !== 32'hFFC00000 || so !== 1'b0 || lat !== 4) begin
            errors++;
            $display("FAIL b2b_step4: got %h so=%b at +%0d, required ffc00000 so=0 at +4",
                     r, so, lat);
        end
    endtask

    task automatic test_abort_idle();
        int act;
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b1, 3'd0, 32'h00000001, 5'd5);
        act = 0;
        repeat (4) begin
            @(posedge clock); #1;
            if (if1.busy || if1.done) act++;
        end
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h00000001, 5'd5);
        checks++;
        if (act !== 0) begin
            errors++;
            $display("FAIL abort_blocks_start: busy/done cycles=%0d, required 0", act);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_clear();
        test_start_ignored();
        test_back_to_back();
        test_abort_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
